led_pattern_engine: RTL and testbench

- Parametrised LED animation sequencer driving an N-bit LED bank from the watch top level.
- Six selectable patterns, programmable frame rate, finite or infinite repeat count, pause/blank via activate, start/stop control, done pulse.
- Sits beside the mode/alarm logic; the alarm controller pulses start and waits for done.

---
 rtl/led_pattern_pkg.sv | 61 ++++++
 rtl/led_pattern_engine_if.sv | 29 ++
 rtl/led_tick_gen.sv | 32 +++
 rtl/led_pattern_engine.sv | 124 ++++++++++++
 tb/tb_led_pattern_engine.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   mode_e        : pattern encodings (0-5 valid, 6/7 rejected)
//   state_e       : sequencer states
//   mode_valid    : true for an implemented pattern select
//   mode_period   : frames per pass for a pattern on an n-LED bank
//   pattern_frame : LED image of frame i, returned LSB-aligned in a
//                   LED_MAX-wide vector; callers truncate to their bank
package led_pattern_pkg;

    localparam int unsigned LED_MAX = 64;

    typedef enum logic [2:0] {
        MODE_CHASE    = 3'd0,
        MODE_BOUNCE   = 3'd1,
        MODE_CONVERGE = 3'd2,
        MODE_FILL     = 3'd3,
        MODE_BLINK    = 3'd4,
        MODE_ALT      = 3'd5
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic mode_valid(input logic [2:0] m);
        return (m <= 3'd5);
    endfunction

    function automatic int unsigned mode_period(input mode_e m, input int unsigned n);
        case (m)
            MODE_CHASE, MODE_CONVERGE: return n;
            MODE_BOUNCE:               return 2 * n - 2;
            MODE_FILL:                 return 2 * n;
            default:                   return 2;
        endcase
    endfunction

    function automatic logic [LED_MAX-1:0] pattern_frame(input mode_e m,
                                                         input int unsigned i,
                                                         input int unsigned n);
        logic [LED_MAX-1:0] one;
        logic [LED_MAX-1:0] all_n;
        logic [LED_MAX-1:0] f;
        one   = 64'd1;
        all_n = (one << n) - one;   // n = 64 wraps to all ones
        f     = '0;
        case (m)
            MODE_CHASE:    f = (i < n / 2) ? (one << i) : (one << (n - 1 - (i - n / 2)));
            MODE_BOUNCE:   f = (i < n) ? (one << i) : (one << (2 * n - 2 - i));
            MODE_CONVERGE: f = (one << i) | (one << (n - 1 - i));
            MODE_FILL:     f = (i < n) ? ((one << (i + 1)) - one)
                                       : ((one << (2 * n - 1 - i)) - one);
            MODE_BLINK:    f = (i == 0) ? all_n : '0;
            MODE_ALT:      f = ((i == 0) ? {32{2'b01}} : {32{2'b10}}) & all_n;
            default:       f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the alarm/mode logic and the LED sequencer.
//   master : drives activate, start, stop, mode, step_div, loops;
//            receives leds, busy, done
//   slave  : the sequencer side
interface led_pattern_engine_if #(
    parameter int unsigned N_LEDS = 16,
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned LOOP_W = 8
);
    logic              activate;
    logic              start;
    logic              stop;
    logic [2:0]        mode;
    logic [DIV_W-1:0]  step_div;
    logic [LOOP_W-1:0] loops;
    logic [N_LEDS-1:0] leds;
    logic              busy;
    logic              done;

    modport master (
        output activate, start, stop, mode, step_div, loops,
        input  leds, busy, done
    );

    modport slave (
        input  activate, start, stop, mode, step_div, loops,
        output leds, busy, done
    );
endinterface

// File: rtl/led_tick_gen.sv
// Programmable frame-rate divider.
//   clk, rst : clock, synchronous active-low reset
//   clr      : restart count at 0 (wins over en)
//   en       : count this cycle
//   period   : cycles per tick; 0 behaves as 1
//   tick     : high on the last counted cycle of each period (while en)
module led_tick_gen #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last;

    assign last = (period == '0) ? '0 : period - DIV_W'(1);
    assign tick = en && (cnt_q == last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
        end
    end
endmodule

// File: rtl/led_pattern_engine.sv
// LED animation sequencer for the watch LED bank.
//   clk, rst : clock, synchronous active-low reset
//   bus      : led_pattern_engine_if slave
//              in : activate, start, stop, mode, step_div, loops
//              out: leds (registered), busy, done (one-cycle pulse)
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int unsigned N_LEDS = 16,
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned LOOP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    led_pattern_engine_if.slave   bus
);
    localparam int unsigned FRAME_W = $clog2(2 * N_LEDS);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DIV_W-1:0]  per_q, per_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic [LOOP_W-1:0] pass_inc;
    logic [FRAME_W-1:0] last_frame;
    logic              shown_q, shown_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              done_q, done_d;
    logic              start_go;
    logic              tick;
    logic              div_clr;
    logic              div_en;

    // Timing only advances on cycles that follow a displayed cycle, so a
    // frame resumed after a pause is shown again before the divider moves.
    assign div_en  = (state_q == ST_RUN) && bus.activate && shown_q;
    assign div_clr = start_go || (state_d == ST_IDLE);

    led_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (div_clr),
        .en     (div_en),
        .period (per_q),
        .tick   (tick)
    );

    assign last_frame = FRAME_W'(mode_period(mode_q, N_LEDS) - 1);
    assign pass_inc   = pass_q + LOOP_W'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        per_d    = per_q;
        loops_d  = loops_q;
        frame_d  = frame_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        start_go = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else if (bus.start && mode_valid(bus.mode)) begin
            start_go = 1'b1;
            state_d  = ST_RUN;
            mode_d   = mode_e'(bus.mode);
            per_d    = bus.step_div;
            loops_d  = bus.loops;
            frame_d  = '0;
            pass_d   = '0;
        end else if (state_q == ST_RUN && tick) begin
            if (frame_q == last_frame) begin
                frame_d = '0;
                if (loops_q != '0) begin
                    if (pass_inc == loops_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pass_d = pass_inc;
                    end
                end
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        if (state_d == ST_IDLE) begin
            frame_d = '0;
            pass_d  = '0;
        end

        shown_d = (state_d == ST_RUN) && bus.activate;
        leds_d  = shown_d ? N_LEDS'(pattern_frame(mode_d, 32'(frame_d), N_LEDS)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CHASE;
            per_q   <= '0;
            loops_q <= '0;
            frame_q <= '0;
            pass_q  <= '0;
            shown_q <= 1'b0;
            leds_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            per_q   <= per_d;
            loops_q <= loops_d;
            frame_q <= frame_d;
            pass_q  <= pass_d;
            shown_q <= shown_d;
            leds_q  <= leds_d;
            done_q  <= done_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (N_LEDS = 16): expected LED images
// come from an independent per-bit pattern model and are queued per cycle.
module tb_led_pattern_engine;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_pattern_engine_if #(.N_LEDS(16), .DIV_W(24), .LOOP_W(8)) bus ();

    led_pattern_engine #(.N_LEDS(16), .DIV_W(24), .LOOP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [15:0] leds;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] ref_pat(input int m, input int i);
        logic [15:0] f;
        f = '0;
        for (int b = 0; b < 16; b++) begin
            case (m)
                0: f[b] = (i < 8) ? (b == i) : (b == 15 - (i - 8));
                1: f[b] = (i < 16) ? (b == i) : (b == 30 - i);
                2: f[b] = (b == i) || (b == 15 - i);
                3: f[b] = (i < 16) ? (b <= i) : (b < 31 - i);
                4: f[b] = (i == 0);
                5: f[b] = (i == 0) ? (b % 2 == 0) : (b % 2 == 1);
                default: f[b] = 1'b0;
            endcase
        end
        return f;
    endfunction

    // Queue the expectation for the coming edge, advance, then compare.
    task automatic cyc(input string tag, input logic [15:0] l, input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.leds = l; e.busy = b; e.done = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus.leds === e.leds) else begin
            errors++;
            $error("FAIL %s leds observed %h expected %h", e.tag, bus.leds, e.leds);
        end
        checks++;
        assert (bus.busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy observed %b expected %b", e.tag, bus.busy, e.busy);
        end
        checks++;
        assert (bus.done === e.done) else begin
            errors++;
            $error("FAIL %s done observed %b expected %b", e.tag, bus.done, e.done);
        end
    endtask

    task automatic go(input logic [2:0] m, input logic [23:0] d, input logic [7:0] lp);
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.step_div = d;
        bus.loops    = lp;
    endtask

    initial begin
        rst          = 1'b0;
        bus.activate = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.mode     = 3'd0;
        bus.step_div = 24'd0;
        bus.loops    = 8'd0;

        cyc("reset0", 16'h0000, 1'b0, 1'b0);
        cyc("reset1", 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("idle", 16'h0000, 1'b0, 1'b0);

        // CHASE, one frame per cycle, single pass
        go(3'd0, 24'd1, 8'd1);
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("chase%0d", i), ref_pat(0, i), 1'b1, 1'b0);
            bus.start = 1'b0;
        end
        cyc("chase_done", 16'h0000, 1'b0, 1'b1);
        cyc("chase_after", 16'h0000, 1'b0, 1'b0);

        // CONVERGE, three cycles per frame, two passes
        go(3'd2, 24'd3, 8'd2);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++)
                for (int r = 0; r < 3; r++) begin
                    cyc($sformatf("conv_p%0d_i%0d_r%0d", p, i, r), ref_pat(2, i), 1'b1, 1'b0);
                    bus.start = 1'b0;
                end
        cyc("conv_done", 16'h0000, 1'b0, 1'b1);
        cyc("conv_after", 16'h0000, 1'b0, 1'b0);

        // FILL, step_div 0, infinite, pause at frame 4
        go(3'd3, 24'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("fill%0d", i), ref_pat(3, i), 1'b1, 1'b0);
            bus.start = 1'b0;
        end
        bus.activate = 1'b0;
        for (int k = 0; k < 5; k++) cyc($sformatf("pause%0d", k), 16'h0000, 1'b1, 1'b0);
        bus.activate = 1'b1;
        cyc("resume_held", 16'h001F, 1'b1, 1'b0);
        for (int i = 5; i < 32; i++) cyc($sformatf("fill%0d", i), ref_pat(3, i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc($sformatf("fill_wrap%0d", i), ref_pat(3, i), 1'b1, 1'b0);
        bus.stop = 1'b1;
        cyc("fill_stop", 16'h0000, 1'b0, 1'b0);
        bus.stop = 1'b0;

        // BOUNCE then simultaneous start+stop
        go(3'd1, 24'd1, 8'd0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("bounce%0d", i), ref_pat(1, i), 1'b1, 1'b0);
            bus.start = 1'b0;
        end
        go(3'd1, 24'd1, 8'd0);
        bus.stop = 1'b1;
        cyc("startstop", 16'h0000, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cyc("startstop_idle", 16'h0000, 1'b0, 1'b0);

        // BLINK, restart into ALT, invalid mode 7 ignored
        go(3'd4, 24'd1, 8'd0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("blink%0d", i), ref_pat(4, i % 2), 1'b1, 1'b0);
            bus.start = 1'b0;
        end
        go(3'd5, 24'd1, 8'd0);
        cyc("alt0", 16'h5555, 1'b1, 1'b0);
        bus.start = 1'b0;
        cyc("alt1", 16'hAAAA, 1'b1, 1'b0);
        cyc("alt2", 16'h5555, 1'b1, 1'b0);
        go(3'd7, 24'd9, 8'd1);
        cyc("mode7_ign0", 16'hAAAA, 1'b1, 1'b0);
        bus.start = 1'b0;
        cyc("mode7_ign1", 16'h5555, 1'b1, 1'b0);

        // reset mid-sequence
        rst = 1'b0;
        cyc("midreset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cyc($sformatf("post_reset%0d", k), 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
